// File: rtl/noise_ctrl_pkg.sv
// rtl/noise_ctrl_pkg.sv - shared types and constants for the noise window controller
package noise_ctrl_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t PEPPER_VAL      = 8'd0;
  localparam pix_t SALT_VAL        = 8'd255;
  localparam pix_t DEFAULT_PAD_VAL = 8'd128;

  localparam int WIN_N = 9;
  localparam int TL = 0;
  localparam int T  = 1;
  localparam int TR = 2;
  localparam int L  = 3;
  localparam int C  = 4;
  localparam int R  = 5;
  localparam int BL = 6;
  localparam int B  = 7;
  localparam int BR = 8;

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/noise_window_controller_line_delay.sv
// rtl/noise_window_controller_line_delay.sv - enabled pixel shift delay of DEPTH stages, reset-free storage
module line_delay
  import noise_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] d,
  output logic [PIX_W-1:0] q
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[DEPTH-1];

endmodule

// File: rtl/noise_window_controller.sv
// rtl/noise_window_controller.sv - 3x3 window sequencer with border padding and valid/ready flow control
// Optional pepper/salt pixel counters are built when NOISE_STATS_EN is defined.
module noise_window_controller
  import noise_ctrl_pkg::*;
#(
  parameter int   IMG_W   = 256,
  parameter int   IMG_H   = 256,
  parameter pix_t PAD_VAL = DEFAULT_PAD_VAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PIX_W-1:0]           s_pix,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PIX_W-1:0]           X0,
  output logic [PIX_W-1:0]           X1,
  output logic [PIX_W-1:0]           X2,
  output logic [PIX_W-1:0]           X3,
  output logic [PIX_W-1:0]           X4,
  output logic [PIX_W-1:0]           X5,
  output logic [PIX_W-1:0]           X6,
  output logic [PIX_W-1:0]           X7,
  output logic [PIX_W-1:0]           X8,
  output logic [$clog2(IMG_H)-1:0]   m_row,
  output logic [$clog2(IMG_W)-1:0]   m_col,
  output logic                       m_last,
  output logic                       busy,
  output logic                       frame_done
`ifdef NOISE_STATS_EN
  ,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] pepper_cnt,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] salt_cnt
`endif
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int CNT_W = $clog2(NPIX);
  localparam int DRN_W = $clog2(IMG_W + 2);

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(NPIX - 1);
  localparam logic [DRN_W-1:0] DRAIN_N    = DRN_W'(IMG_W + 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0] pix_cnt;
  logic [DRN_W-1:0] drain_cnt;
  logic [ROW_W-1:0] ctr_row;
  logic [COL_W-1:0] ctr_col;
  logic             accept;
  logic             shift;
  logic             emit;
  pix_t             in_pix;

  // Tap registers; each row's three taps are seen before the shift, so the
  // incoming pixel itself is the bottom-right tap.
  pix_t bot0, bot1;
  pix_t mid0, mid1, mid2;
  pix_t top0, top1, top2;
  pix_t ld_a_q, ld_b_q;

  pix_t win_raw  [WIN_N];
  pix_t win_mask [WIN_N];
  pix_t win_q    [WIN_N];

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    accept     = 1'b0;
    shift      = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = PRIME;
      end
      PRIME: begin
        s_ready = 1'b1;
        accept  = s_valid;
        shift   = accept;
        if (accept && pix_cnt == PRIME_LAST) state_nxt = RUN;
      end
      RUN: begin
        s_ready = !m_valid || m_ready;
        accept  = s_valid && s_ready;
        shift   = accept;
        emit    = accept;
        if (accept && pix_cnt == FRAME_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        shift = (drain_cnt != DRAIN_N) && (!m_valid || m_ready);
        emit  = shift;
        if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_pix = (state == DRAIN) ? PAD_VAL : s_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      drain_cnt <= '0;
      ctr_row   <= '0;
      ctr_col   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        pix_cnt   <= '0;
        drain_cnt <= '0;
        ctr_row   <= '0;
        ctr_col   <= '0;
      end
      if (accept) pix_cnt <= pix_cnt + 1'b1;
      if (state == DRAIN && shift) drain_cnt <= drain_cnt + 1'b1;
      if (emit) begin
        if (ctr_col == COL_LAST) begin
          ctr_col <= '0;
          ctr_row <= ctr_row + 1'b1;
        end else begin
          ctr_col <= ctr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      bot0 <= in_pix;
      bot1 <= bot0;
      mid0 <= ld_a_q;
      mid1 <= mid0;
      mid2 <= mid1;
      top0 <= ld_b_q;
      top1 <= top0;
      top2 <= top1;
    end
  end

  line_delay #(.DEPTH(IMG_W - 3)) u_line_a (
    .clk (clk),
    .en  (shift),
    .d   (bot1),
    .q   (ld_a_q)
  );

  line_delay #(.DEPTH(IMG_W - 3)) u_line_b (
    .clk (clk),
    .en  (shift),
    .d   (mid2),
    .q   (ld_b_q)
  );

  always_comb begin
    win_raw[TL] = top2;
    win_raw[T]  = top1;
    win_raw[TR] = top0;
    win_raw[L]  = mid2;
    win_raw[C]  = mid1;
    win_raw[R]  = mid0;
    win_raw[BL] = bot1;
    win_raw[B]  = bot0;
    win_raw[BR] = in_pix;
    win_mask = win_raw;
    if (ctr_row == '0) begin
      win_mask[TL] = PAD_VAL;
      win_mask[T]  = PAD_VAL;
      win_mask[TR] = PAD_VAL;
    end
    if (ctr_row == ROW_LAST) begin
      win_mask[BL] = PAD_VAL;
      win_mask[B]  = PAD_VAL;
      win_mask[BR] = PAD_VAL;
    end
    if (ctr_col == '0) begin
      win_mask[TL] = PAD_VAL;
      win_mask[L]  = PAD_VAL;
      win_mask[BL] = PAD_VAL;
    end
    if (ctr_col == COL_LAST) begin
      win_mask[TR] = PAD_VAL;
      win_mask[R]  = PAD_VAL;
      win_mask[BR] = PAD_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_row   <= '0;
      m_col   <= '0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else if (emit) begin
      m_valid <= 1'b1;
      m_last  <= (ctr_row == ROW_LAST) && (ctr_col == COL_LAST);
      m_row   <= ctr_row;
      m_col   <= ctr_col;
      win_q   <= win_mask;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign X0 = win_q[TL];
  assign X1 = win_q[T];
  assign X2 = win_q[TR];
  assign X3 = win_q[L];
  assign X4 = win_q[C];
  assign X5 = win_q[R];
  assign X6 = win_q[BL];
  assign X7 = win_q[B];
  assign X8 = win_q[BR];

`ifdef NOISE_STATS_EN
  localparam int STAT_W = $clog2(NPIX + 1);

  logic [STAT_W-1:0] pep_acc;
  logic [STAT_W-1:0] salt_acc;

  // Running counts become visible only at frame end, so a reader never sees a partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pep_acc    <= '0;
      salt_acc   <= '0;
      pepper_cnt <= '0;
      salt_cnt   <= '0;
    end else begin
      if (state == IDLE && start) begin
        pep_acc  <= '0;
        salt_acc <= '0;
      end else if (accept) begin
        if (s_pix == PEPPER_VAL) pep_acc <= pep_acc + 1'b1;
        if (s_pix == SALT_VAL) salt_acc <= salt_acc + 1'b1;
      end
      if (state == DONE) begin
        pepper_cnt <= pep_acc;
        salt_cnt   <= salt_acc;
      end
    end
  end
`endif

endmodule
